// File: rtl/comm_pkg.sv
// Shared constants for the frame scheduler: FSM state encoding and the
// power-on stage offsets.
package comm_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam int unsigned DefTransOff = 128;
  localparam int unsigned DefTestOff  = 144;
  localparam int unsigned DefDecOff   = 160;

  // Slots advance and stage starts may fire only in these states.
  function automatic logic st_active(input logic [1:0] st);
    return (st == StRun) || (st == StDrain);
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Frame slot counter: counts 0..FRAME_LEN-1 while enabled, otherwise holds 0.
// frame_end flags the last slot of the frame.
module slot_counter #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             count_en,
  output logic [CNT_W-1:0] slot,
  output logic             frame_end
);

  logic [CNT_W-1:0] slot_q, slot_d;

  assign frame_end = (slot_q == CNT_W'(FRAME_LEN - 1));
  assign slot      = slot_q;

  always_comb begin
    slot_d = slot_q;
    if (!count_en) begin
      slot_d = '0;
    end else if (frame_end) begin
      slot_d = '0;
    end else begin
      slot_d = slot_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: runs a slot counter per frame and fires trans/test/dec
// stage starts at programmable slots, tracking pending work and overruns.
module frame_scheduler
  import comm_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_trans_off,
  input  logic [CNT_W-1:0] cfg_test_off,
  input  logic [CNT_W-1:0] cfg_dec_off,
  input  logic             trans_done,
  input  logic             test_done,
  input  logic             dec_done,
  input  logic             ovr_clr,
  output logic             trans_start,
  output logic             test_start,
  output logic             dec_start,
  output logic             frame_start,
  output logic [CNT_W-1:0] slot,
  output logic [2:0]       pending,
  output logic [2:0]       overrun,
  output logic             running
);

  logic [1:0]            state_q, state_d;
  logic                  active;
  logic                  frame_end;
  logic [2:0][CNT_W-1:0] off_q;
  logic [2:0]            done_vec;
  logic [2:0]            hit;
  logic [2:0]            start_vec;
  logic [2:0]            ovr_set;
  logic [2:0]            pending_q, pending_d;
  logic [2:0]            overrun_q, overrun_d;

  assign active   = st_active(state_q);
  assign done_vec = {dec_done, test_done, trans_done};

  slot_counter #(
    .CNT_W     (CNT_W),
    .FRAME_LEN (FRAME_LEN)
  ) u_slot_counter (
    .sysclk    (sysclk),
    .reset     (reset),
    .count_en  (active),
    .slot      (slot),
    .frame_end (frame_end)
  );

  // Dropping enable never truncates a frame: RUN goes through DRAIN unless the
  // frame is already on its last slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (!enable) state_d = frame_end ? StIdle : StDrain;
      end
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (frame_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Offsets are only reprogrammed while stopped, so a frame never mixes configs.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      off_q[0] <= CNT_W'(DefTransOff);
      off_q[1] <= CNT_W'(DefTestOff);
      off_q[2] <= CNT_W'(DefDecOff);
    end else if (cfg_load && (state_q == StIdle)) begin
      off_q[0] <= cfg_trans_off;
      off_q[1] <= cfg_test_off;
      off_q[2] <= cfg_dec_off;
    end
  end

  // A done arriving on the offset slot retires the previous run in time to
  // let the new start through.
  always_comb begin
    hit       = '0;
    start_vec = '0;
    ovr_set   = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i]       = active && (slot == off_q[i]);
      start_vec[i] = hit[i] && (!pending_q[i] || done_vec[i]);
      ovr_set[i]   = hit[i] && pending_q[i] && !done_vec[i];
    end
  end

  assign pending_d = (pending_q & ~done_vec) | start_vec;
  assign overrun_d = ovr_set | (overrun_q & ~{3{ovr_clr}});

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign trans_start = start_vec[0];
  assign test_start  = start_vec[1];
  assign dec_start   = start_vec[2];
  assign frame_start = (state_q == StRun) && (slot == '0);
  assign running     = (state_q == StRun);
  assign pending     = pending_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: stage responder returns done pulses a
// fixed delay after each start; main sequence checks slots, pulses and flags.
module tb_frame_scheduler;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned FRAME_LEN = 256;

  logic             sysclk;
  logic             reset;
  logic             enable;
  logic             cfg_load;
  logic [CNT_W-1:0] cfg_trans_off;
  logic [CNT_W-1:0] cfg_test_off;
  logic [CNT_W-1:0] cfg_dec_off;
  logic             trans_done;
  logic             test_done;
  logic             dec_done;
  logic             ovr_clr;
  logic             trans_start;
  logic             test_start;
  logic             dec_start;
  logic             frame_start;
  logic [CNT_W-1:0] slot;
  logic [2:0]       pending;
  logic [2:0]       overrun;
  logic             running;

  logic [2:0] starts;
  logic [2:0] done_r;
  logic [2:0] man_done;
  logic [2:0] auto_en;
  logic [2:0] seen;
  int         cnt [3];
  int         n_tests;
  int         n_fail;
  int         period;

  frame_scheduler #(
    .CNT_W     (CNT_W),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .enable        (enable),
    .cfg_load      (cfg_load),
    .cfg_trans_off (cfg_trans_off),
    .cfg_test_off  (cfg_test_off),
    .cfg_dec_off   (cfg_dec_off),
    .trans_done    (trans_done),
    .test_done     (test_done),
    .dec_done      (dec_done),
    .ovr_clr       (ovr_clr),
    .trans_start   (trans_start),
    .test_start    (test_start),
    .dec_start     (dec_start),
    .frame_start   (frame_start),
    .slot          (slot),
    .pending       (pending),
    .overrun       (overrun),
    .running       (running)
  );

  assign starts     = {dec_start, test_start, trans_start};
  assign trans_done = done_r[0] | man_done[0];
  assign test_done  = done_r[1] | man_done[1];
  assign dec_done   = done_r[2] | man_done[2];

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Stage model: done arrives 5 cycles after the start cycle when enabled.
  initial begin
    done_r = '0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    forever begin
      @(negedge sysclk);
      seen = starts;
      @(posedge sysclk);
      #1;
      for (int i = 0; i < 3; i++) begin
        done_r[i] = 1'b0;
        if (cnt[i] != 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0 && auto_en[i]) done_r[i] = 1'b1;
        end
        if (seen[i]) cnt[i] = 4;
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [CNT_W-1:0] obs,
                      input logic [CNT_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advances at least one cycle, then to the next negedge where slot == target.
  task automatic wait_slot(input logic [CNT_W-1:0] target);
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (slot !== target && n < 1000);
    chk8("wait_slot", slot, target);
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    enable        = 1'b0;
    cfg_load      = 1'b0;
    ovr_clr       = 1'b0;
    man_done      = '0;
    auto_en       = 3'b111;
    cfg_trans_off = '0;
    cfg_test_off  = '0;
    cfg_dec_off   = '0;
    repeat (2) @(negedge sysclk);
    chk8("rst_slot", slot, 8'd0);
    chk1("rst_running", running, 1'b0);
    chk1("rst_frame_start", frame_start, 1'b0);
    chk3("rst_starts", starts, 3'b000);
    chk3("rst_pending", pending, 3'b000);
    chk3("rst_overrun", overrun, 3'b000);
    @(posedge sysclk);
    #1 reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Test 1: default offsets, periodic starts, no overrun
    do_reset();
    enable = 1'b1;
    @(negedge sysclk);
    chk1("t1_idle_running", running, 1'b0);
    chk1("t1_idle_fs", frame_start, 1'b0);
    @(negedge sysclk);
    chk1("t1_running", running, 1'b1);
    chk8("t1_slot0", slot, 8'd0);
    chk1("t1_frame_start", frame_start, 1'b1);
    wait_slot(8'd127);
    chk3("t1_no_start_127", starts, 3'b000);
    wait_slot(8'd128);
    chk3("t1_trans_start", starts, 3'b001);
    chk3("t1_pend_at_128", pending, 3'b000);
    @(negedge sysclk);
    chk3("t1_pend_at_129", pending, 3'b001);
    wait_slot(8'd134);
    chk3("t1_pend_cleared", pending, 3'b000);
    wait_slot(8'd144);
    chk3("t1_test_start", starts, 3'b010);
    wait_slot(8'd160);
    chk3("t1_dec_start", starts, 3'b100);
    wait_slot(8'd0);
    chk1("t1_frame2_start", frame_start, 1'b1);
    wait_slot(8'd128);
    chk3("t1_trans_start2", starts, 3'b001);
    period = 0;
    do begin
      @(negedge sysclk);
      period++;
    end while (!trans_start && period < 600);
    chk8("t1_period", 8'(period), 8'(FRAME_LEN));
    chk1("t1_period_hi", period > 255, 1'b1);
    chk3("t1_overrun", overrun, 3'b000);

    // Test 2: reprogrammed offsets; load during RUN ignored
    do_reset();
    cfg_trans_off = 8'd10;
    cfg_test_off  = 8'd10;
    cfg_dec_off   = 8'd200;
    cfg_load      = 1'b1;
    @(posedge sysclk);
    #1 cfg_load = 1'b0;
    enable = 1'b1;
    wait_slot(8'd10);
    chk3("t2_coincide", starts, 3'b011);
    wait_slot(8'd128);
    chk3("t2_old_off_128", starts, 3'b000);
    wait_slot(8'd200);
    chk3("t2_dec", starts, 3'b100);
    cfg_trans_off = 8'd50;
    cfg_test_off  = 8'd50;
    cfg_dec_off   = 8'd50;
    @(posedge sysclk);
    #1 cfg_load = 1'b1;
    @(posedge sysclk);
    #1 cfg_load = 1'b0;
    wait_slot(8'd10);
    chk3("t2_run_load_ign", starts, 3'b011);
    wait_slot(8'd50);
    chk3("t2_no_start_50", starts, 3'b000);

    // Test 3: test_done withheld -> suppression and sticky overrun
    do_reset();
    auto_en = 3'b101;
    enable  = 1'b1;
    wait_slot(8'd144);
    chk3("t3_first_test", starts, 3'b010);
    wait_slot(8'd145);
    chk3("t3_pend", pending, 3'b010);
    chk3("t3_ovr0", overrun, 3'b000);
    wait_slot(8'd144);
    chk3("t3_suppressed", starts, 3'b000);
    chk3("t3_ovr_not_yet", overrun, 3'b000);
    @(negedge sysclk);
    chk3("t3_ovr_set", overrun, 3'b010);
    wait_slot(8'd143);
    @(posedge sysclk);
    #1 ovr_clr = 1'b1;
    @(negedge sysclk);
    chk3("t3_suppressed2", starts, 3'b000);
    @(posedge sysclk);
    #1 ovr_clr = 1'b0;
    @(negedge sysclk);
    chk3("t3_set_beats_clr", overrun, 3'b010);
    wait_slot(8'd200);
    @(posedge sysclk);
    #1 ovr_clr = 1'b1;
    @(posedge sysclk);
    #1 ovr_clr = 1'b0;
    @(negedge sysclk);
    chk3("t3_ovr_cleared", overrun, 3'b000);
    chk3("t3_pend_kept", pending, 3'b010);

    // Test 4: drain completes the frame; re-enable in DRAIN has no gap
    do_reset();
    enable = 1'b1;
    wait_slot(8'd50);
    enable = 1'b0;
    @(negedge sysclk);
    chk1("t4_drain_running", running, 1'b0);
    chk8("t4_drain_slot", slot, 8'd51);
    wait_slot(8'd128);
    chk3("t4_drain_start", starts, 3'b001);
    wait_slot(8'd255);
    chk1("t4_255_running", running, 1'b0);
    @(negedge sysclk);
    chk8("t4_idle_slot", slot, 8'd0);
    chk1("t4_idle_fs", frame_start, 1'b0);
    @(negedge sysclk);
    chk8("t4_idle_hold", slot, 8'd0);
    chk1("t4_idle_running", running, 1'b0);
    enable = 1'b1;
    @(negedge sysclk);
    chk1("t4_rerun", running, 1'b1);
    chk1("t4_rerun_fs", frame_start, 1'b1);
    wait_slot(8'd50);
    enable = 1'b0;
    wait_slot(8'd100);
    chk1("t4_drain2", running, 1'b0);
    enable = 1'b1;
    @(negedge sysclk);
    chk1("t4_resume", running, 1'b1);
    chk8("t4_resume_slot", slot, 8'd101);
    wait_slot(8'd0);
    chk1("t4_wrap_running", running, 1'b1);
    chk1("t4_wrap_fs", frame_start, 1'b1);

    // Test 5: done on the offset slot lets the start through
    do_reset();
    auto_en = 3'b110;
    enable  = 1'b1;
    wait_slot(8'd128);
    chk3("t5_first_trans", starts, 3'b001);
    wait_slot(8'd127);
    @(posedge sysclk);
    #1 man_done = 3'b001;
    @(negedge sysclk);
    chk3("t5_start_with_done", starts, 3'b001);
    @(posedge sysclk);
    #1 man_done = 3'b000;
    @(negedge sysclk);
    chk3("t5_pend", pending, 3'b001);
    chk3("t5_no_ovr", overrun, 3'b000);

    // Test 6: asynchronous reset mid-frame, then clean restart
    do_reset();
    enable = 1'b1;
    wait_slot(8'd145);
    chk3("t6_pend_before", pending, 3'b010);
    reset = 1'b0;
    #1;
    chk8("t6_slot", slot, 8'd0);
    chk1("t6_running", running, 1'b0);
    chk3("t6_pending", pending, 3'b000);
    chk3("t6_starts", starts, 3'b000);
    chk1("t6_fs", frame_start, 1'b0);
    @(posedge sysclk);
    #1 reset = 1'b1;
    @(negedge sysclk);
    chk1("t6_release_running", running, 1'b0);
    chk1("t6_release_fs", frame_start, 1'b0);
    @(negedge sysclk);
    chk1("t6_restart_running", running, 1'b1);
    chk8("t6_restart_slot", slot, 8'd0);
    chk1("t6_restart_fs", frame_start, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
